rs_multi_entry: RTL and testbench
=================================

Name: rs_multi_entry

Overview:
Parametrised N-entry reservation station, successor to the single-entry ALU station. Accepts one dispatched instruction per cycle from dispatch and tracks source-operand readiness by ROB tag. Captures operand values from the CDB broadcast and issues one ready entry per cycle to its functional unit.

Parameters:
RS_SIZE, 8, number of entries (power of two, >=2)
TAG_W, $clog2(`ROB_SIZE), ROB tag width
XLEN, `XLEN, operand width
PAY_W, $bits(RS_PAYLOAD), opaque payload width (inst, PC, NPC, opa/opb select, alu_func, dest_reg_idx, mem/branch/halt/illegal/csr flags, func_unit)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash: invalidate all entries
dp_valid  in  1  dispatch request
dp_payload  in  PAY_W  instruction payload
dp_rob_tag  in  TAG_W  destination ROB tag
dp_rs1_ready / dp_rs2_ready  in  1 each  operand value already valid
dp_rs1_tag / dp_rs2_tag  in  TAG_W each  producer tag when not ready
dp_rs1_value / dp_rs2_value  in  XLEN each  operand value when ready
rs_full  out  1  no free entry (registered-state based)
rs_free_count  out  $clog2(RS_SIZE)+1  free entries
cdb_valid  in  1  broadcast valid
cdb_tag  in  TAG_W  completing tag
cdb_value  in  XLEN  completing value
ex_ready  in  1  FU accepts issue this cycle
issue_valid  out  1  an entry is being presented
issue_payload  out  PAY_W
issue_rob_tag  out  TAG_W
issue_rs1_value / issue_rs2_value  out  XLEN each

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: all busy bits clear; rs_full=0, rs_free_count=RS_SIZE, issue_valid=0, all issue data outputs 0.
- flush has the same effect as reset. It also overrides a same-cycle dispatch and any CDB capture.
- Entry state: busy, payload, rob_tag, and per operand {ready, tag, value}.
- Dispatch: when dp_valid && !rs_full, write the lowest-index free entry at the clock edge.
  - dp_valid while rs_full is ignored. Dispatch must hold it.
- Dispatch-side forwarding (mandatory): if an operand is not ready, cdb_valid=1, and cdb_tag equals that operand's tag in the same cycle, the entry is written with ready=1 and value=cdb_value.
- Wakeup: each cycle with cdb_valid, every busy entry whose operand is not ready and whose tag matches sets ready=1 and value=cdb_value. Both operands may wake in the same cycle.
- Readiness: an entry is ready when busy && rs1.ready && rs2.ready.
  - A newly dispatched entry is eligible for issue the following cycle at the earliest (0-cycle dispatch-to-issue is not allowed).
  - An entry woken by the CDB is eligible the cycle after the broadcast.
- Issue:
  - Combinational select among ready entries (default priority: lowest index).
  - issue_valid=1 when any entry is ready; outputs show the selected entry.
  - If ex_ready=1, the selected entry's busy bit clears at the edge. Otherwise everything holds.
  - issue_* must stay stable while issue_valid && !ex_ready, unless a higher-priority entry becomes ready.
- Free-slot reuse: a slot freed by issue is usable by dispatch in the next cycle. rs_full and rs_free_count come from registered busy bits only.
- Simultaneous events in one cycle: dispatch, wakeup and issue on different entries all take effect together.
- Boundary cases:
  - All entries busy and none ready: issue_valid=0, rs_full=1.
  - cdb_valid with no matching tag has no effect.
  - Duplicate tags on rs1 and rs2 both wake.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined: each entry holds an age counter of $clog2(RS_SIZE) bits.
  - A newly dispatched entry gets age 0.
  - All other busy entries increment (saturating) on each dispatch.
  - Issue selects the ready entry with the largest age; ties go to the lowest index.
- Undefined: no age state; fixed lowest-index priority.

Decomposition:
- Shared package (sys_defs): RS_PAYLOAD packed struct, RS_OPERAND struct {ready, tag, value}, RS_ENTRY struct, FUNC_UNIT enum, ROB_SIZE/XLEN constants.
- One sub-module: rs_select. It is a parametrised priority picker (ready vector, plus optional ages, in; one-hot grant plus valid out). The same instance finds the free slot for dispatch, fed with ~busy and no ages.

Test Plan:
- Reset, then dispatch 8 entries with both operands ready, ex_ready=0 -> rs_full=1 after the 8th edge, rs_free_count=0. Then ex_ready=1 -> entries 0..7 issue on consecutive cycles, free_count climbs back to 8.
- Dispatch entry with rs1 waiting on tag 5 and rs2 ready=0x10. Broadcast CDB tag 5, value 0xDEAD two cycles later -> issue_valid rises the next cycle, issue_rs1_value=0xDEAD, issue_rs2_value=0x10.
- Dispatch waiting on tag 3 while cdb_tag=3, value 0x77 in the same cycle -> next cycle issue_valid=1, issue_rs1_value=0x77.
- Full station: issue one entry (ex_ready=1) while dp_valid=1 -> dispatch ignored that cycle, accepted the following cycle into the freed index.
- flush asserted with 4 busy entries and a concurrent dispatch -> next cycle free_count=8, issue_valid=0.
- With RS_OLDEST_FIRST_EN: dispatch A (entry 0, waiting), then B (entry 1, ready), then wake A -> A issues before B.

Source files
------------

// File: rtl/rs_multi_entry_pkg.sv
// Shared types and constants for the multi-entry reservation station.
// The ROB size and operand width constants are the system defaults that the
// station parameters fall back to.
package rs_multi_entry_pkg;

  localparam int SYS_ROB_SIZE = 32;
  localparam int SYS_XLEN     = 32;
  localparam int SYS_TAG_W    = $clog2(SYS_ROB_SIZE);

  typedef enum logic [2:0] {
    FU_ALU    = 3'd0,
    FU_MULT   = 3'd1,
    FU_LOAD   = 3'd2,
    FU_STORE  = 3'd3,
    FU_BRANCH = 3'd4
  } FUNC_UNIT;

  // Opaque to the station: carried from dispatch to issue untouched.
  typedef struct packed {
    logic [31:0]          inst;
    logic [SYS_XLEN-1:0]  pc;
    logic [SYS_XLEN-1:0]  npc;
    logic [1:0]           opa_select;
    logic [1:0]           opb_select;
    logic [4:0]           alu_func;
    logic [4:0]           dest_reg_idx;
    logic                 rd_mem;
    logic                 wr_mem;
    logic                 cond_branch;
    logic                 uncond_branch;
    logic                 halt;
    logic                 illegal;
    logic                 csr_op;
    FUNC_UNIT             func_unit;
  } RS_PAYLOAD;

  typedef struct packed {
    logic                 ready;
    logic [SYS_TAG_W-1:0] tag;
    logic [SYS_XLEN-1:0]  value;
  } RS_OPERAND;

  typedef struct packed {
    logic                 busy;
    RS_PAYLOAD            payload;
    logic [SYS_TAG_W-1:0] rob_tag;
    RS_OPERAND            rs1;
    RS_OPERAND            rs2;
  } RS_ENTRY;

endpackage

// File: rtl/rs_multi_entry_select.sv
// Parametrised priority picker. Grants the requesting entry with the largest
// age; ties (including all-zero ages) go to the lowest index, so feeding zero
// ages gives plain lowest-index priority.
module rs_select #(
  parameter int N     = 8,
  parameter int AGE_W = 3
) (
  input  logic [N-1:0]            req_i,
  input  logic [N-1:0][AGE_W-1:0] age_i,
  output logic [N-1:0]            gnt_o,
  output logic                    valid_o
);

  logic [AGE_W-1:0] best_age;
  logic             found;

  // Linear scan; strict '>' keeps the earliest index on equal ages.
  always_comb begin
    gnt_o    = '0;
    found    = 1'b0;
    best_age = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (!found || (age_i[i] > best_age))) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        found    = 1'b1;
        best_age = age_i[i];
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/rs_multi_entry.sv
// N-entry reservation station: dispatch into the lowest free slot, operand
// wakeup from the CDB (including same-cycle forwarding at dispatch), and one
// issue per cycle to the functional unit.
// Optional build macro RS_OLDEST_FIRST_EN: per-entry saturating age counters,
// issue prefers the oldest ready entry. Without it, lowest index wins.
// Handshake: issue_valid/ex_ready -- an entry leaves the station on a cycle
// where both are high; while issue_valid && !ex_ready the presented entry is
// held unless a higher-priority entry becomes ready. Dispatch has no ready
// signal: dp_valid is accepted only when rs_full is low, otherwise the
// dispatcher must hold it.
module rs_multi_entry
  import rs_multi_entry_pkg::*;
#(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = SYS_TAG_W,
  parameter int XLEN    = SYS_XLEN,
  parameter int PAY_W   = $bits(RS_PAYLOAD)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dp_valid,
  input  logic [PAY_W-1:0]           dp_payload,
  input  logic [TAG_W-1:0]           dp_rob_tag,
  input  logic                       dp_rs1_ready,
  input  logic                       dp_rs2_ready,
  input  logic [TAG_W-1:0]           dp_rs1_tag,
  input  logic [TAG_W-1:0]           dp_rs2_tag,
  input  logic [XLEN-1:0]            dp_rs1_value,
  input  logic [XLEN-1:0]            dp_rs2_value,
  output logic                       rs_full,
  output logic [$clog2(RS_SIZE):0]   rs_free_count,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_value,
  input  logic                       ex_ready,
  output logic                       issue_valid,
  output logic [PAY_W-1:0]           issue_payload,
  output logic [TAG_W-1:0]           issue_rob_tag,
  output logic [XLEN-1:0]            issue_rs1_value,
  output logic [XLEN-1:0]            issue_rs2_value
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;
  localparam int AGE_W = IDX_W;

  // Entry state
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] rs1_rdy_q, rs1_rdy_d;
  logic [RS_SIZE-1:0] rs2_rdy_q, rs2_rdy_d;
  logic [PAY_W-1:0]   pay_q     [RS_SIZE];
  logic [PAY_W-1:0]   pay_d     [RS_SIZE];
  logic [TAG_W-1:0]   rob_q     [RS_SIZE];
  logic [TAG_W-1:0]   rob_d     [RS_SIZE];
  logic [TAG_W-1:0]   rs1_tag_q [RS_SIZE];
  logic [TAG_W-1:0]   rs1_tag_d [RS_SIZE];
  logic [TAG_W-1:0]   rs2_tag_q [RS_SIZE];
  logic [TAG_W-1:0]   rs2_tag_d [RS_SIZE];
  logic [XLEN-1:0]    rs1_val_q [RS_SIZE];
  logic [XLEN-1:0]    rs1_val_d [RS_SIZE];
  logic [XLEN-1:0]    rs2_val_q [RS_SIZE];
  logic [XLEN-1:0]    rs2_val_d [RS_SIZE];

  logic [RS_SIZE-1:0][AGE_W-1:0] iss_age;
  logic [RS_SIZE-1:0]            ready_vec;
  logic [RS_SIZE-1:0]            iss_gnt;
  logic                          iss_valid;
  logic [IDX_W-1:0]              iss_idx;
  logic [RS_SIZE-1:0]            free_gnt;
  logic                          free_valid;
  logic                          dp_fire;
  logic                          iss_fire;
  logic                          dp_rs1_rdy_fwd, dp_rs2_rdy_fwd;
  logic [XLEN-1:0]               dp_rs1_val_fwd, dp_rs2_val_fwd;
  logic [CNT_W-1:0]              free_cnt;

`ifdef RS_OLDEST_FIRST_EN
  logic [RS_SIZE-1:0][AGE_W-1:0] age_q, age_d;
  assign iss_age = age_q;
`else
  assign iss_age = '0;
`endif

  // Readiness uses registered operand state only, so a dispatch or wakeup
  // becomes issuable no earlier than the following cycle.
  assign ready_vec = busy_q & rs1_rdy_q & rs2_rdy_q;

  rs_select #(.N(RS_SIZE), .AGE_W(AGE_W)) u_issue_sel (
    .req_i   (ready_vec),
    .age_i   (iss_age),
    .gnt_o   (iss_gnt),
    .valid_o (iss_valid)
  );

  rs_select #(.N(RS_SIZE), .AGE_W(AGE_W)) u_free_sel (
    .req_i   (~busy_q),
    .age_i   ('0),
    .gnt_o   (free_gnt),
    .valid_o (free_valid)
  );

  // One-hot issue grant to an index for the output mux.
  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (iss_gnt[i]) iss_idx = IDX_W'(i);
    end
  end

  // Count free slots from the registered busy bits.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy_q[i]) free_cnt = free_cnt + CNT_W'(1);
    end
  end

  assign rs_full       = !free_valid;
  assign rs_free_count = free_cnt;
  assign dp_fire       = dp_valid && free_valid;
  assign iss_fire      = iss_valid && ex_ready;

  assign issue_valid     = iss_valid;
  assign issue_payload   = iss_valid ? pay_q[iss_idx]     : '0;
  assign issue_rob_tag   = iss_valid ? rob_q[iss_idx]     : '0;
  assign issue_rs1_value = iss_valid ? rs1_val_q[iss_idx] : '0;
  assign issue_rs2_value = iss_valid ? rs2_val_q[iss_idx] : '0;

  // Capture a value broadcast in the same cycle as dispatch.
  always_comb begin
    dp_rs1_rdy_fwd = dp_rs1_ready;
    dp_rs1_val_fwd = dp_rs1_value;
    dp_rs2_rdy_fwd = dp_rs2_ready;
    dp_rs2_val_fwd = dp_rs2_value;
    if (!dp_rs1_ready && cdb_valid && (cdb_tag == dp_rs1_tag)) begin
      dp_rs1_rdy_fwd = 1'b1;
      dp_rs1_val_fwd = cdb_value;
    end
    if (!dp_rs2_ready && cdb_valid && (cdb_tag == dp_rs2_tag)) begin
      dp_rs2_rdy_fwd = 1'b1;
      dp_rs2_val_fwd = cdb_value;
    end
  end

  // Next state: wakeup, issue release and dispatch write touch disjoint
  // entries (the free slot is never busy), so they compose in one cycle.
  always_comb begin
    busy_d    = busy_q;
    rs1_rdy_d = rs1_rdy_q;
    rs2_rdy_d = rs2_rdy_q;
    pay_d     = pay_q;
    rob_d     = rob_q;
    rs1_tag_d = rs1_tag_q;
    rs2_tag_d = rs2_tag_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
`ifdef RS_OLDEST_FIRST_EN
    age_d     = age_q;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (cdb_valid && busy_q[i]) begin
        if (!rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_tag)) begin
          rs1_rdy_d[i] = 1'b1;
          rs1_val_d[i] = cdb_value;
        end
        if (!rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_tag)) begin
          rs2_rdy_d[i] = 1'b1;
          rs2_val_d[i] = cdb_value;
        end
      end
    end
    if (iss_fire) busy_d[iss_idx] = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (dp_fire && free_gnt[i]) begin
        busy_d[i]    = 1'b1;
        pay_d[i]     = dp_payload;
        rob_d[i]     = dp_rob_tag;
        rs1_rdy_d[i] = dp_rs1_rdy_fwd;
        rs1_tag_d[i] = dp_rs1_tag;
        rs1_val_d[i] = dp_rs1_val_fwd;
        rs2_rdy_d[i] = dp_rs2_rdy_fwd;
        rs2_tag_d[i] = dp_rs2_tag;
        rs2_val_d[i] = dp_rs2_val_fwd;
      end
`ifdef RS_OLDEST_FIRST_EN
      if (dp_fire) begin
        if (free_gnt[i]) begin
          age_d[i] = '0;
        end else if (busy_q[i] && (age_q[i] != {AGE_W{1'b1}})) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
`endif
    end
  end

  // State register; flush behaves exactly like reset and wins over any
  // same-cycle dispatch or CDB capture.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      busy_q    <= '0;
      rs1_rdy_q <= '0;
      rs2_rdy_q <= '0;
`ifdef RS_OLDEST_FIRST_EN
      age_q     <= '0;
`endif
      for (int i = 0; i < RS_SIZE; i++) begin
        pay_q[i]     <= '0;
        rob_q[i]     <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      rs1_rdy_q <= rs1_rdy_d;
      rs2_rdy_q <= rs2_rdy_d;
`ifdef RS_OLDEST_FIRST_EN
      age_q     <= age_d;
`endif
      for (int i = 0; i < RS_SIZE; i++) begin
        pay_q[i]     <= pay_d[i];
        rob_q[i]     <= rob_d[i];
        rs1_tag_q[i] <= rs1_tag_d[i];
        rs2_tag_q[i] <= rs2_tag_d[i];
        rs1_val_q[i] <= rs1_val_d[i];
        rs2_val_q[i] <= rs2_val_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rs_multi_entry.sv
// Directed bench for rs_multi_entry: fill/drain, CDB wakeup, dispatch-time
// forwarding, non-matching and duplicate tags, full-station retry, flush,
// and issue priority. Optional build macro RS_OLDEST_FIRST_EN selects the
// oldest-first expected issue order.
module tb_rs_multi_entry;
  import rs_multi_entry_pkg::*;

  localparam int RS_SIZE = 8;
  localparam int TAG_W   = SYS_TAG_W;
  localparam int XLEN    = SYS_XLEN;
  localparam int PAY_W   = $bits(RS_PAYLOAD);

  logic                  clock = 1'b0;
  logic                  reset, flush;
  logic                  dp_valid;
  logic [PAY_W-1:0]      dp_payload;
  logic [TAG_W-1:0]      dp_rob_tag;
  logic                  dp_rs1_ready, dp_rs2_ready;
  logic [TAG_W-1:0]      dp_rs1_tag, dp_rs2_tag;
  logic [XLEN-1:0]       dp_rs1_value, dp_rs2_value;
  logic                  rs_full;
  logic [$clog2(RS_SIZE):0] rs_free_count;
  logic                  cdb_valid;
  logic [TAG_W-1:0]      cdb_tag;
  logic [XLEN-1:0]       cdb_value;
  logic                  ex_ready;
  logic                  issue_valid;
  logic [PAY_W-1:0]      issue_payload;
  logic [TAG_W-1:0]      issue_rob_tag;
  logic [XLEN-1:0]       issue_rs1_value, issue_rs2_value;

  int n_cmp = 0;
  int n_err = 0;
  logic [TAG_W-1:0] exp_tags [RS_SIZE];

  rs_multi_entry #(.RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .XLEN(XLEN), .PAY_W(PAY_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .flush           (flush),
    .dp_valid        (dp_valid),
    .dp_payload      (dp_payload),
    .dp_rob_tag      (dp_rob_tag),
    .dp_rs1_ready    (dp_rs1_ready),
    .dp_rs2_ready    (dp_rs2_ready),
    .dp_rs1_tag      (dp_rs1_tag),
    .dp_rs2_tag      (dp_rs2_tag),
    .dp_rs1_value    (dp_rs1_value),
    .dp_rs2_value    (dp_rs2_value),
    .rs_full         (rs_full),
    .rs_free_count   (rs_free_count),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_value       (cdb_value),
    .ex_ready        (ex_ready),
    .issue_valid     (issue_valid),
    .issue_payload   (issue_payload),
    .issue_rob_tag   (issue_rob_tag),
    .issue_rs1_value (issue_rs1_value),
    .issue_rs2_value (issue_rs2_value)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [PAY_W-1:0] mk_pay(input int k);
    logic [PAY_W-1:0] p;
    p = '0;
    p[31:0] = 32'hA000_0000 + k;
    p[PAY_W-1 -: 8] = 8'(k + 8'h40);
    return p;
  endfunction

  task automatic dp_drive(input int k, input logic [TAG_W-1:0] rob,
                          input logic r1, input logic [TAG_W-1:0] t1, input logic [XLEN-1:0] v1,
                          input logic r2, input logic [TAG_W-1:0] t2, input logic [XLEN-1:0] v2);
    dp_valid     = 1'b1;
    dp_payload   = mk_pay(k);
    dp_rob_tag   = rob;
    dp_rs1_ready = r1;
    dp_rs1_tag   = t1;
    dp_rs1_value = v1;
    dp_rs2_ready = r2;
    dp_rs2_tag   = t2;
    dp_rs2_value = v2;
  endtask

  task automatic dp_idle();
    dp_valid     = 1'b0;
    dp_payload   = '0;
    dp_rob_tag   = '0;
    dp_rs1_ready = 1'b0;
    dp_rs1_tag   = '0;
    dp_rs1_value = '0;
    dp_rs2_ready = 1'b0;
    dp_rs2_tag   = '0;
    dp_rs2_value = '0;
  endtask

  task automatic drain_one();
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    settle();
  endtask

  initial begin
    // Reset
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
    dp_idle();
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_full", rs_full, 0);
    chk("rst_free", rs_free_count, 8);
    chk("rst_ivalid", issue_valid, 0);
    chk("rst_ipay", issue_payload, 0);
    chk("rst_itag", issue_rob_tag, 0);
    chk("rst_irs1", issue_rs1_value, 0);

    // Fill all 8 entries with ready operands while the FU stalls
    for (int k = 0; k < 8; k++) begin
      dp_drive(k, TAG_W'(k), 1'b1, '0, XLEN'(32'h100 + k), 1'b1, '0, XLEN'(32'h200 + k));
      tick();
      chk("fill_free", rs_free_count, 7 - k);
    end
    dp_idle();
    settle();
    chk("fill_full", rs_full, 1);
    chk("fill_ivalid", issue_valid, 1);
    chk("fill_itag", issue_rob_tag, 0);
    tick();
    chk("stall_itag", issue_rob_tag, 0);
    chk("stall_free", rs_free_count, 0);

    // Drain in order 0..7
    ex_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("drain_ivalid", issue_valid, 1);
      chk("drain_itag", issue_rob_tag, k);
      chk("drain_rs1", issue_rs1_value, 32'h100 + k);
      chk("drain_rs2", issue_rs2_value, 32'h200 + k);
      chk("drain_pay", issue_payload, mk_pay(k));
      tick();
      chk("drain_free", rs_free_count, k + 1);
    end
    ex_ready = 1'b0;
    settle();
    chk("drain_empty", issue_valid, 0);
    chk("drain_notfull", rs_full, 0);

    // CDB wakeup two cycles after dispatch
    dp_drive(20, 5'd9, 1'b0, 5'd5, '0, 1'b1, '0, 32'h10);
    tick();
    dp_idle();
    settle();
    chk("wake_wait", issue_valid, 0);
    tick();
    cdb_valid = 1'b1; cdb_tag = 5'd5; cdb_value = 32'hDEAD;
    settle();
    chk("wake_same_cyc", issue_valid, 0);
    tick();
    cdb_valid = 1'b0;
    settle();
    chk("wake_ivalid", issue_valid, 1);
    chk("wake_rs1", issue_rs1_value, 32'hDEAD);
    chk("wake_rs2", issue_rs2_value, 32'h10);
    chk("wake_itag", issue_rob_tag, 9);
    drain_one();
    chk("wake_freed", rs_free_count, 8);

    // Dispatch-time forwarding from CDB
    dp_drive(21, 5'd4, 1'b0, 5'd3, '0, 1'b1, '0, 32'h22);
    cdb_valid = 1'b1; cdb_tag = 5'd3; cdb_value = 32'h77;
    tick();
    dp_idle();
    cdb_valid = 1'b0;
    settle();
    chk("fwd_ivalid", issue_valid, 1);
    chk("fwd_rs1", issue_rs1_value, 32'h77);
    chk("fwd_rs2", issue_rs2_value, 32'h22);
    drain_one();

    // Non-matching broadcast, then duplicate tag on both operands
    dp_drive(22, 5'd11, 1'b0, 5'd12, '0, 1'b0, 5'd12, '0);
    tick();
    dp_idle();
    cdb_valid = 1'b1; cdb_tag = 5'd8; cdb_value = 32'h99;
    tick();
    cdb_valid = 1'b0;
    settle();
    chk("nomatch_ivalid", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_value = 32'h55;
    tick();
    cdb_valid = 1'b0;
    settle();
    chk("dup_ivalid", issue_valid, 1);
    chk("dup_rs1", issue_rs1_value, 32'h55);
    chk("dup_rs2", issue_rs2_value, 32'h55);
    drain_one();
    chk("dup_freed", rs_free_count, 8);

    // Full station: dispatch while issuing is refused, retried next cycle
    for (int k = 0; k < 8; k++) begin
      dp_drive(30 + k, TAG_W'(16 + k), 1'b1, '0, XLEN'(32'h400 + k), 1'b1, '0, '0);
      tick();
    end
    dp_drive(40, 5'd30, 1'b1, '0, 32'h300, 1'b1, '0, 32'h301);
    ex_ready = 1'b1;
    settle();
    chk("full_before", rs_full, 1);
    tick();
    ex_ready = 1'b0;
    settle();
    chk("full_ign_free", rs_free_count, 1);
    chk("full_ign_full", rs_full, 0);
    chk("full_ign_itag", issue_rob_tag, 17);
    tick();
    dp_idle();
    settle();
    chk("full_acc_free", rs_free_count, 0);
    chk("full_acc_full", rs_full, 1);
`ifdef RS_OLDEST_FIRST_EN
    for (int k = 0; k < 7; k++) exp_tags[k] = TAG_W'(17 + k);
    exp_tags[7] = 5'd30;
`else
    exp_tags[0] = 5'd30;
    for (int k = 1; k < 8; k++) exp_tags[k] = TAG_W'(16 + k);
`endif
    ex_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("full_drain_itag", issue_rob_tag, exp_tags[k]);
      tick();
    end
    ex_ready = 1'b0;
    settle();
    chk("full_drain_free", rs_free_count, 8);

    // Flush with 4 busy entries and a concurrent dispatch
    for (int k = 0; k < 4; k++) begin
      dp_drive(50 + k, TAG_W'(k), 1'b1, '0, 32'h1, 1'b1, '0, 32'h2);
      tick();
    end
    chk("pre_flush_free", rs_free_count, 4);
    dp_drive(60, 5'd7, 1'b1, '0, 32'h3, 1'b1, '0, 32'h4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dp_idle();
    settle();
    chk("flush_free", rs_free_count, 8);
    chk("flush_ivalid", issue_valid, 0);
    chk("flush_full", rs_full, 0);
    chk("flush_itag", issue_rob_tag, 0);

    // A waits (entry 0), B ready (entry 1); waking A preempts B
    dp_drive(70, 5'd1, 1'b0, 5'd6, '0, 1'b1, '0, 32'h2);
    tick();
    dp_drive(71, 5'd2, 1'b1, '0, 32'hB1, 1'b1, '0, 32'hB2);
    tick();
    dp_idle();
    settle();
    chk("ab_b_shown", issue_rob_tag, 2);
    cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_value = 32'h66;
    settle();
    chk("ab_b_hold", issue_rob_tag, 2);
    tick();
    cdb_valid = 1'b0;
    settle();
    chk("ab_a_first", issue_rob_tag, 1);
    chk("ab_a_rs1", issue_rs1_value, 32'h66);
    drain_one();
    chk("ab_b_second", issue_rob_tag, 2);
    chk("ab_b_rs1", issue_rs1_value, 32'hB1);
    drain_one();
    chk("ab_empty", issue_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
